// File: rtl/datamem_arbiter.sv
// datamem_arbiter: shares one single-port datamem (sync write, combinational read) between two
// requesters using a REQ/ACK handshake per requester and round-robin on contention.
//
// Ports:
//   CLK, RST                  clock (posedge) and asynchronous active-high reset
//   REQ0/1, WEN0/1            access request (held until ACK) and write enable (1 = write)
//   ADD0/1, DIN0/1            access address and write data, stable while REQ high
//   ACK0/1                    one-cycle completion pulse to the served requester
//   DOUT0/1                   read data (old word on a write), held until that port's next ACK
//   MEM_ADD/DATAIN/WEN        drive the datamem; MEM_DATAOUT is its combinational read data
//   BUSY                      high while an access is in flight (ACCESS or RESP)
//
// Every service takes three cycles: grant edge (IDLE->ACCESS), completion edge (ACCESS->RESP,
// memory write commits and read data is captured), recovery edge (RESP->IDLE).
module datamem_arbiter #(
  parameter int unsigned AddWidth  = 2,
  parameter int unsigned DataWidth = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic                 WEN0,
  input  logic                 WEN1,
  input  logic [AddWidth-1:0]  ADD0,
  input  logic [AddWidth-1:0]  ADD1,
  input  logic [DataWidth-1:0] DIN0,
  input  logic [DataWidth-1:0] DIN1,
  output logic                 ACK0,
  output logic                 ACK1,
  output logic [DataWidth-1:0] DOUT0,
  output logic [DataWidth-1:0] DOUT1,
  output logic [AddWidth-1:0]  MEM_ADD,
  output logic [DataWidth-1:0] MEM_DATAIN,
  output logic                 MEM_WEN,
  input  logic [DataWidth-1:0] MEM_DATAOUT,
  output logic                 BUSY
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic                 gnt_q, gnt_d;
  logic                 wen_q, wen_d;
  logic [AddWidth-1:0]  add_q, add_d;
  logic [DataWidth-1:0] din_q, din_d;
  logic [DataWidth-1:0] dout0_q, dout0_d;
  logic [DataWidth-1:0] dout1_q, dout1_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 pick;

  // Round-robin: on a tie the requester that was not served last wins.
  always_comb begin
    if (REQ0 && REQ1) begin
      pick = ~last_q;
    end else begin
      pick = REQ1;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wen_d   = wen_q;
    add_d   = add_q;
    din_d   = din_q;
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (REQ0 || REQ1) begin
          gnt_d   = pick;
          wen_d   = pick ? WEN1 : WEN0;
          add_d   = pick ? ADD1 : ADD0;
          din_d   = pick ? DIN1 : DIN0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        // Read data is sampled before the write lands, so a write returns the old word.
        if (gnt_q) begin
          dout1_d = MEM_DATAOUT;
          ack1_d  = 1'b1;
        end else begin
          dout0_d = MEM_DATAOUT;
          ack0_d  = 1'b1;
        end
        last_d  = gnt_q;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wen_q   <= 1'b0;
      add_q   <= '0;
      din_q   <= '0;
      dout0_q <= '0;
      dout1_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wen_q   <= wen_d;
      add_q   <= add_d;
      din_q   <= din_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  // MEM_WEN comes only from registered state, so an async reset kills a pending write at once.
  assign MEM_WEN    = (state_q == StAccess) && wen_q;
  assign MEM_ADD    = add_q;
  assign MEM_DATAIN = din_q;
  assign BUSY       = (state_q != StIdle);
  assign ACK0       = ack0_q;
  assign ACK1       = ack1_q;
  assign DOUT0      = dout0_q;
  assign DOUT1      = dout1_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Testbench for datamem_arbiter with a behavioural datamem and a transaction-level reference
// model that predicts the outputs from the handshake rules; a compare process checks the DUT
// on every falling edge, and directed scenarios add hand-computed literal expectations.
module tb_datamem_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          CLK  = 1'b0;
  logic          RST  = 1'b1;
  logic          REQ0 = 1'b0;
  logic          REQ1 = 1'b0;
  logic          WEN0 = 1'b0;
  logic          WEN1 = 1'b0;
  logic [AW-1:0] ADD0 = '0;
  logic [AW-1:0] ADD1 = '0;
  logic [DW-1:0] DIN0 = '0;
  logic [DW-1:0] DIN1 = '0;
  logic          ACK0, ACK1, MEM_WEN, BUSY;
  logic [DW-1:0] DOUT0, DOUT1, MEM_DATAIN, MEM_DATAOUT;
  logic [AW-1:0] MEM_ADD;

  datamem_arbiter #(
    .AddWidth (AW),
    .DataWidth(DW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ0       (REQ0),
    .REQ1       (REQ1),
    .WEN0       (WEN0),
    .WEN1       (WEN1),
    .ADD0       (ADD0),
    .ADD1       (ADD1),
    .DIN0       (DIN0),
    .DIN1       (DIN1),
    .ACK0       (ACK0),
    .ACK1       (ACK1),
    .DOUT0      (DOUT0),
    .DOUT1      (DOUT1),
    .MEM_ADD    (MEM_ADD),
    .MEM_DATAIN (MEM_DATAIN),
    .MEM_WEN    (MEM_WEN),
    .MEM_DATAOUT(MEM_DATAOUT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Address 5 starts at zero; others hold 0x30+addr so old-word returns are distinguishable.
  function automatic logic [DW-1:0] init_word(input int a);
    return (a == 5) ? 8'h00 : 8'(8'h30 + a);
  endfunction

  // Physical datamem: synchronous write, combinational read.
  logic [DW-1:0] phys_mem [16];
  bit            phys_loaded = 1'b0;
  always @(posedge CLK) begin
    if (!phys_loaded) begin
      for (int i = 0; i < 16; i++) phys_mem[i] <= init_word(i);
      phys_loaded <= 1'b1;
    end else if (MEM_WEN) begin
      phys_mem[MEM_ADD] <= MEM_DATAIN;
    end
  end
  assign MEM_DATAOUT = phys_mem[MEM_ADD];

  // Reference model: each grant owns a 3-cycle slot (grant, complete, recover). It keeps its
  // own copy of memory contents and never looks at DUT outputs.
  function automatic logic winner(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return (last == 1'b0);
    return r1;
  endfunction

  int unsigned   slot;
  logic          m_last, m_g, m_wen, m_ack0, m_ack1;
  logic [AW-1:0] m_add;
  logic [DW-1:0] m_din, m_dout0, m_dout1;
  logic [DW-1:0] ref_mem [16];
  bit            ref_loaded = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      if (!ref_loaded) begin
        for (int i = 0; i < 16; i++) ref_mem[i] <= init_word(i);
        ref_loaded <= 1'b1;
      end
      slot    <= 0;
      m_last  <= 1'b1;
      m_g     <= 1'b0;
      m_wen   <= 1'b0;
      m_add   <= '0;
      m_din   <= '0;
      m_ack0  <= 1'b0;
      m_ack1  <= 1'b0;
      m_dout0 <= '0;
      m_dout1 <= '0;
    end else begin
      m_ack0 <= 1'b0;
      m_ack1 <= 1'b0;
      if (slot == 0) begin
        if (REQ0 || REQ1) begin
          m_g   <= winner(REQ0, REQ1, m_last);
          m_wen <= winner(REQ0, REQ1, m_last) ? WEN1 : WEN0;
          m_add <= winner(REQ0, REQ1, m_last) ? ADD1 : ADD0;
          m_din <= winner(REQ0, REQ1, m_last) ? DIN1 : DIN0;
          slot  <= 1;
        end
      end else if (slot == 1) begin
        if (m_g) begin
          m_dout1 <= ref_mem[m_add];
          m_ack1  <= 1'b1;
        end else begin
          m_dout0 <= ref_mem[m_add];
          m_ack0  <= 1'b1;
        end
        if (m_wen) ref_mem[m_add] <= m_din;
        m_last <= m_g;
        slot   <= 2;
      end else begin
        slot <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("ACK0", 32'(ACK0), 32'(m_ack0));
      chk("ACK1", 32'(ACK1), 32'(m_ack1));
      chk("DOUT0", 32'(DOUT0), 32'(m_dout0));
      chk("DOUT1", 32'(DOUT1), 32'(m_dout1));
      chk("BUSY", 32'(BUSY), 32'(slot != 0));
      chk("MEM_WEN", 32'(MEM_WEN), 32'((slot == 1) && m_wen));
      chk("MEM_ADD", 32'(MEM_ADD), 32'(m_add));
      chk("MEM_DATAIN", 32'(MEM_DATAIN), 32'(m_din));
    end
  end

  task automatic drive(input int port, input logic wen, input logic [AW-1:0] add,
                       input logic [DW-1:0] din);
    if (port == 0) begin
      REQ0 = 1'b1; WEN0 = wen; ADD0 = add; DIN0 = din;
    end else begin
      REQ1 = 1'b1; WEN1 = wen; ADD1 = add; DIN1 = din;
    end
  endtask

  // Bounded wait for the port's ACK; returns the DOUT visible with it.
  task automatic wait_ack(input int port, output logic [DW-1:0] dout);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      if ((port == 0 && ACK0) || (port == 1 && ACK1)) seen = 1'b1;
    end
    dout = (port == 0) ? DOUT0 : DOUT1;
    chk("ack_seen", 32'(seen), 32'd1);
    @(posedge CLK);
    #1;
    if (port == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
  endtask

  task automatic do_req(input int port, input logic wen, input logic [AW-1:0] add,
                        input logic [DW-1:0] din, output logic [DW-1:0] dout);
    @(posedge CLK);
    #1;
    drive(port, wen, add, din);
    wait_ack(port, dout);
  endtask

  logic [DW-1:0] d;
  int            order [4];
  int            at    [4];
  int            n_ack;
  int            pulses;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge CLK);
    cmp_en = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_wen", 32'(MEM_WEN), 32'd0);
    chk("rst_ack0", 32'(ACK0), 32'd0);
    chk("rst_dout0", 32'(DOUT0), 32'd0);
    chk("rst_dout1", 32'(DOUT1), 32'd0);
    chk("rst_add", 32'(MEM_ADD), 32'd0);

    // Contention after reset: both reads held -> 0,1,0,1, three cycles apart.
    for (int i = 0; i < 4; i++) order[i] = 9;
    n_ack = 0;
    @(posedge CLK);
    #1;
    drive(0, 1'b0, 4'd1, 8'h00);
    drive(1, 1'b0, 4'd8, 8'h00);
    for (int n = 0; n < 40 && n_ack < 4; n++) begin
      @(negedge CLK);
      if (ACK0) begin
        order[n_ack] = 0; at[n_ack] = cyc; n_ack++;
      end else if (ACK1) begin
        order[n_ack] = 1; at[n_ack] = cyc; n_ack++;
      end
    end
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    chk("rr_count", 32'(n_ack), 32'd4);
    chk("rr_first", 32'(order[0]), 32'd0);
    chk("rr_second", 32'(order[1]), 32'd1);
    chk("rr_third", 32'(order[2]), 32'd0);
    chk("rr_fourth", 32'(order[3]), 32'd1);
    chk("rr_gap", 32'(at[1] - at[0]), 32'd3);
    chk("rr_gap2", 32'(at[3] - at[2]), 32'd3);
    chk("rr_dout0", 32'(DOUT0), 32'h31);
    chk("rr_dout1", 32'(DOUT1), 32'h38);

    // Single write then read back.
    do_req(0, 1'b1, 4'd3, 8'hA5, d);
    chk("wr_old_word", 32'(d), 32'h33);
    do_req(0, 1'b0, 4'd3, 8'h00, d);
    chk("rd_new_word", 32'(d), 32'hA5);

    // Cross-port.
    do_req(1, 1'b1, 4'd7, 8'h3C, d);
    chk("x_wr_old", 32'(d), 32'h37);
    do_req(0, 1'b0, 4'd7, 8'h00, d);
    chk("x_rd0", 32'(d), 32'h3C);
    chk("x_dout1_held", 32'(DOUT1), 32'h37);

    // Read-before-write.
    do_req(1, 1'b1, 4'd2, 8'h11, d);
    do_req(1, 1'b1, 4'd2, 8'h22, d);
    chk("rbw_old", 32'(d), 32'h11);
    do_req(1, 1'b0, 4'd2, 8'h00, d);
    chk("rbw_new", 32'(d), 32'h22);

    // Idle, then REQ0 held across services: one ACK per 3 cycles.
    repeat (4) begin
      @(negedge CLK);
      chk("idle_busy", 32'(BUSY), 32'd0);
      chk("idle_wen", 32'(MEM_WEN), 32'd0);
    end
    pulses = 0;
    @(posedge CLK);
    #1;
    drive(0, 1'b0, 4'd3, 8'h00);
    repeat (10) begin
      @(negedge CLK);
      if (ACK0) pulses++;
    end
    REQ0 = 1'b0;
    chk("held_pulses", 32'(pulses), 32'd3);

    // Reset during the ACCESS cycle of a write.
    @(posedge CLK);
    #1;
    drive(0, 1'b1, 4'd5, 8'hFF);
    @(posedge CLK);
    #1;
    chk("mid_wen_before", 32'(MEM_WEN), 32'd1);
    RST = 1'b1;
    #1;
    chk("mid_wen_after", 32'(MEM_WEN), 32'd0);
    chk("mid_busy", 32'(BUSY), 32'd0);
    chk("mid_ack0", 32'(ACK0), 32'd0);
    chk("mid_dout0", 32'(DOUT0), 32'd0);
    chk("mid_dout1", 32'(DOUT1), 32'd0);
    chk("mid_add", 32'(MEM_ADD), 32'd0);
    chk("mid_din", 32'(MEM_DATAIN), 32'd0);
    @(posedge CLK);
    #1;
    chk("mid_mem5", 32'(phys_mem[5]), 32'h00);
    RST = 1'b0;
    wait_ack(0, d);
    chk("retry_old", 32'(d), 32'h00);
    @(negedge CLK);
    chk("retry_mem5", 32'(phys_mem[5]), 32'hFF);

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
